wb_slave_arbiter: RTL and testbench

Single-master to N-slave Wishbone address decoder and bridge (16-bit data, 32-bit address) sitting between the bus master and the peripheral slaves. It latches each master request, routes it to the one slave whose address window contains it, forwards the window-relative offset, and returns ack or read data. It also returns an error for unmapped addresses or unresponsive slaves. Module name: `wb_slave_arbiter`.

---
 rtl/wb_arb_pkg.sv | 24 ++
 rtl/wb_addr_decode.sv | 40 ++++
 rtl/wb_slave_arbiter.sv | 154 +++++++++++++++
 tb/tb_wb_slave_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// rtl/wb_arb_pkg.sv - shared types, widths and helpers for the wishbone slave arbiter
package wb_arb_pkg;

  localparam int WB_ADR_W   = 32;
  localparam int WB_DAT_W   = 16;
  localparam int MAX_SLAVES = 32;
  localparam int IDX_W      = 5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  // OR-reduction encoder; only meaningful for a one-hot or all-zero input
  function automatic logic [IDX_W-1:0] onehot_to_index(input logic [MAX_SLAVES-1:0] onehot);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_SLAVES; i++) begin
      if (onehot[i]) idx = idx | IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/wb_addr_decode.sv
// rtl/wb_addr_decode.sv - combinational address window decoder, lowest index wins on overlap
module wb_addr_decode
  import wb_arb_pkg::*;
#(
  parameter int                         NUM_SLAVES = 14,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_ADDR = '0,
  parameter logic [32*NUM_SLAVES-1:0]   SLAVE_HIGH = '0
) (
  input  logic [WB_ADR_W-1:0]   adr,
  output logic [NUM_SLAVES-1:0] hit,
  output logic [IDX_W-1:0]      hit_idx,
  output logic                  miss,
  output logic [WB_ADR_W-1:0]   offset
);

  logic                  found;
  logic [MAX_SLAVES-1:0] hit_ext;

  always_comb begin
    hit    = '0;
    found  = 1'b0;
    offset = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (!found && (adr >= SLAVE_ADDR[32*k +: 32]) && (adr <= SLAVE_HIGH[32*k +: 32])) begin
        hit[k] = 1'b1;
        found  = 1'b1;
        offset = adr - SLAVE_ADDR[32*k +: 32];
      end
    end
  end

  always_comb begin
    hit_ext                 = '0;
    hit_ext[NUM_SLAVES-1:0] = hit;
  end

  assign hit_idx = onehot_to_index(hit_ext);
  assign miss    = !found;

endmodule

// File: rtl/wb_slave_arbiter.sv
// rtl/wb_slave_arbiter.sv - single-master to N-slave wishbone decoder/bridge with timeout
module wb_slave_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_SLAVES = 14,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_ADDR = {
    32'h000d_0000, 32'h000c_0000, 32'h000b_0000, 32'h000a_0000, 32'h0009_0000,
    32'h0008_0000, 32'h0007_0000, 32'h0006_0000, 32'h0005_0000, 32'h0004_0000,
    32'h0003_0000, 32'h0002_0000, 32'h0001_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_HIGH = {
    32'h000d_ffff, 32'h000c_ffff, 32'h000b_ffff, 32'h000a_ffff, 32'h0009_ffff,
    32'h0008_ffff, 32'h0007_ffff, 32'h0006_ffff, 32'h0005_ffff, 32'h0004_ffff,
    32'h0003_ffff, 32'h0002_ffff, 32'h0001_ffff, 32'h0000_ffff},
  parameter int TIMEOUT = 1024
) (
  input  logic                           wb_clk_i,
  input  logic                           wb_rst_i,
  input  logic                           wbm_cyc_i,
  input  logic                           wbm_stb_i,
  input  logic                           wbm_we_i,
  input  logic [1:0]                     wbm_sel_i,
  input  logic [WB_ADR_W-1:0]            wbm_adr_i,
  input  logic [WB_DAT_W-1:0]            wbm_dat_i,
  output logic [WB_DAT_W-1:0]            wbm_dat_o,
  output logic                           wbm_ack_o,
  output logic                           wbm_err_o,
  output logic [NUM_SLAVES-1:0]          wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]          wbs_stb_o,
  output logic                           wbs_we_o,
  output logic [WB_ADR_W-1:0]            wbs_adr_o,
  output logic [WB_DAT_W-1:0]            wbs_dat_o,
  input  logic [WB_DAT_W*NUM_SLAVES-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]          wbs_ack_i
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  arb_state_t            state_q, state_d;
  logic [NUM_SLAVES-1:0] sel_d;
  logic                  we_d, ack_d, err_d;
  logic [WB_ADR_W-1:0]   adr_d;
  logic [WB_DAT_W-1:0]   wdat_d, rdat_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [NUM_SLAVES-1:0] dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic                  dec_miss;
  logic [WB_ADR_W-1:0]   dec_offset;
  logic                  sel_ack;
  logic [WB_DAT_W-1:0]   sel_rdata;
  logic                  sel_unused;

  // byte lanes are always full-word on this bus
  assign sel_unused = ^wbm_sel_i;

  wb_addr_decode #(
    .NUM_SLAVES (NUM_SLAVES),
    .SLAVE_ADDR (SLAVE_ADDR),
    .SLAVE_HIGH (SLAVE_HIGH)
  ) u_decode (
    .adr     (wbm_adr_i),
    .hit     (dec_hit),
    .hit_idx (dec_idx),
    .miss    (dec_miss),
    .offset  (dec_offset)
  );

  always_comb begin
    sel_ack   = 1'b0;
    sel_rdata = '0;
    for (int k = 0; k < NUM_SLAVES; k++) begin
      if (idx_q == IDX_W'(k)) begin
        sel_ack   = wbs_ack_i[k];
        sel_rdata = wbs_dat_i[WB_DAT_W*k +: WB_DAT_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = wbs_stb_o;
    we_d    = wbs_we_o;
    adr_d   = wbs_adr_o;
    wdat_d  = wbs_dat_o;
    rdat_d  = wbm_dat_o;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (dec_miss) begin
            err_d = 1'b1;
          end else begin
            sel_d   = dec_hit;
            we_d    = wbm_we_i;
            adr_d   = dec_offset;
            wdat_d  = wbm_dat_i;
            idx_d   = dec_idx;
            cnt_d   = '0;
            state_d = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        // an ack in the final timeout cycle still completes normally
        if (sel_ack) begin
          sel_d   = '0;
          ack_d   = 1'b1;
          rdat_d  = sel_rdata;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          sel_d   = '0;
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state_q   <= ST_IDLE;
      wbs_cyc_o <= '0;
      wbs_stb_o <= '0;
      wbs_we_o  <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbm_dat_o <= '0;
      wbm_ack_o <= 1'b0;
      wbm_err_o <= 1'b0;
      idx_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      wbs_cyc_o <= sel_d;
      wbs_stb_o <= sel_d;
      wbs_we_o  <= we_d;
      wbs_adr_o <= adr_d;
      wbs_dat_o <= wdat_d;
      wbm_dat_o <= rdat_d;
      wbm_ack_o <= ack_d;
      wbm_err_o <= err_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_slave_arbiter.sv
// tb/tb_wb_slave_arbiter.sv - self-checking bench for wb_slave_arbiter
module tb_wb_slave_arbiter;

  localparam int NS  = 14;
  localparam int TMO = 1024;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            m_cyc, m_stb, m_we;
  logic [1:0]      m_sel;
  logic [31:0]     m_adr;
  logic [15:0]     m_wdat, m_rdat;
  logic            m_ack, m_err;
  logic [NS-1:0]   s_cyc, s_stb, s_ack, ack_r, extra_ack, auto_en;
  logic            s_we;
  logic [31:0]     s_adr;
  logic [15:0]     s_wdat;
  logic [16*NS-1:0] s_rdat;
  logic [15:0]     mem [NS];
  logic [15:0]     exp_mem [NS];

  int tests = 0;
  int fails = 0;

  int          r_n;
  logic        r_ack, r_err, r_after, sn_we;
  logic [15:0] r_dat, r_hold, sn_wdat;
  logic [NS-1:0] sn_stb, sn_cyc, r_stb_end;
  logic [31:0] sn_adr;

  always #5 clk = ~clk;

  wb_slave_arbiter dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst_n),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_we_i  (m_we),
    .wbm_sel_i (m_sel),
    .wbm_adr_i (m_adr),
    .wbm_dat_i (m_wdat),
    .wbm_dat_o (m_rdat),
    .wbm_ack_o (m_ack),
    .wbm_err_o (m_err),
    .wbs_cyc_o (s_cyc),
    .wbs_stb_o (s_stb),
    .wbs_we_o  (s_we),
    .wbs_adr_o (s_adr),
    .wbs_dat_o (s_wdat),
    .wbs_dat_i (s_rdat),
    .wbs_ack_i (s_ack)
  );

  // registered zero-wait slaves with simple storage
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r <= '0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        ack_r[k] <= auto_en[k] & s_stb[k] & ~ack_r[k];
        if (auto_en[k] && s_stb[k] && !ack_r[k] && s_we) mem[k] <= s_wdat;
      end
    end
  end

  assign s_ack = ack_r | extra_ack;

  always_comb begin
    s_rdat = '0;
    for (int k = 0; k < NS; k++) s_rdat[16*k +: 16] = mem[k];
  end

  // reference address map: slave k owns 0x000k_0000..0x000k_ffff
  function automatic int exp_slave(input logic [31:0] a);
    if (a < 32'h000e_0000) return int'(a >> 16);
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
      else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic do_xfer(input logic [31:0] adr, input logic we, input logic [15:0] dat,
                         input int budget);
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = adr; m_we = we; m_wdat = dat;
    m_sel = 2'($urandom_range(0, 3));
    @(posedge clk);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0; m_adr = $urandom; m_we = ~we; m_wdat = 16'($urandom);
    sn_stb = s_stb; sn_cyc = s_cyc; sn_adr = s_adr; sn_we = s_we; sn_wdat = s_wdat;
    r_n = 0;
    while (!(m_ack || m_err) && r_n < budget) begin
      @(negedge clk);
      r_n++;
    end
    r_ack = m_ack; r_err = m_err; r_dat = m_rdat; r_stb_end = s_stb;
    @(negedge clk);
    r_after = m_ack | m_err;
    r_hold  = m_rdat;
  endtask

  task automatic expect_hit(input string tag, input int k, input logic [31:0] off,
                            input logic [15:0] rd);
    check({tag, "_stb"}, 64'(sn_stb), 64'(1) << k);
    check({tag, "_cyc"}, 64'(sn_cyc), 64'(1) << k);
    check({tag, "_adr"}, 64'(sn_adr), 64'(off));
    check({tag, "_ack_err"}, {62'd0, r_ack, r_err}, 64'b10);
    check({tag, "_lat"}, 64'(r_n), 64'd2);
    check({tag, "_dat"}, 64'(r_dat), 64'(rd));
    check({tag, "_pulse"}, 64'(r_after), 64'd0);
    check({tag, "_hold"}, 64'(r_hold), 64'(rd));
  endtask

  initial begin
    int k;
    logic [31:0] a;
    logic        w;
    logic [15:0] d;

    rst_n = 1'b0; m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_sel = 2'b00;
    m_adr = '0; m_wdat = '0; extra_ack = '0; auto_en = '1;
    repeat (3) @(negedge clk);
    check("reset_a", {29'd0, m_ack, m_err, m_rdat, s_we, s_wdat}, 64'd0);
    check("reset_b", {4'd0, s_cyc, s_stb, s_adr}, 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < NS; i++) begin
      do_xfer((32'(i) << 16) | 32'h0000_dead, 1'b1, 16'hbeef, 20);
      exp_mem[i] = 16'hbeef;
      expect_hit("wr", i, 32'h0000_dead, 16'hbeef);
      check("wr_we", 64'(sn_we), 64'd1);
      check("wr_wdat", 64'(sn_wdat), 64'hbeef);
    end

    for (int i = 0; i < NS; i++) begin
      do_xfer((32'(i) << 16) | 32'h0000_dead, 1'b0, 16'h0, 20);
      expect_hit("rd", i, 32'h0000_dead, exp_mem[i]);
      check("rd_we", 64'(sn_we), 64'd0);
    end

    do_xfer(32'h000e_0000, 1'b0, 16'h0, 20);
    check("miss_stb", 64'(sn_stb), 64'd0);
    check("miss_ack_err", {62'd0, r_ack, r_err}, 64'b01);
    check("miss_lat", 64'(r_n), 64'd0);
    check("miss_pulse", 64'(r_after), 64'd0);

    auto_en[3] = 1'b0;
    do_xfer(32'h0003_0010, 1'b0, 16'h0, TMO + 20);
    check("tmo_ack_err", {62'd0, r_ack, r_err}, 64'b01);
    check("tmo_lat", 64'(r_n), 64'(TMO));
    check("tmo_stb_clear", 64'(r_stb_end), 64'd0);
    check("tmo_pulse", 64'(r_after), 64'd0);
    auto_en[3] = 1'b1;
    do_xfer(32'h0004_1234, 1'b0, 16'h0, 20);
    expect_hit("after_tmo", 4, 32'h0000_1234, exp_mem[4]);

    // a foreign ack must not complete the slave 5 transfer
    auto_en[5] = 1'b0;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0005_0100; m_we = 1'b0;
    @(posedge clk);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    check("spur_stb", 64'(s_stb), 64'(1) << 5);
    extra_ack[6] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("spur_ignored", {62'd0, m_ack, m_err}, 64'd0);
    end
    extra_ack[6] = 1'b0;
    extra_ack[5] = 1'b1;
    @(negedge clk);
    extra_ack[5] = 1'b0;
    check("spur_own_ack", {62'd0, m_ack, m_err}, 64'b10);
    check("spur_dat", 64'(m_rdat), 64'(exp_mem[5]));
    check("spur_stb_clear", 64'(s_stb), 64'd0);
    auto_en[5] = 1'b1;

    // reset while BUSY
    auto_en[2] = 1'b0;
    @(negedge clk);
    m_cyc = 1'b1; m_stb = 1'b1; m_adr = 32'h0002_0020; m_we = 1'b1; m_wdat = 16'h1111;
    @(posedge clk);
    @(negedge clk);
    m_cyc = 1'b0; m_stb = 1'b0;
    check("rst_busy_stb", 64'(s_stb), 64'(1) << 2);
    rst_n = 1'b0;
    #1;
    check("rst_mid_a", {29'd0, m_ack, m_err, m_rdat, s_we, s_wdat}, 64'd0);
    check("rst_mid_b", {4'd0, s_cyc, s_stb, s_adr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    auto_en[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_quiet", {62'd0, m_ack, m_err}, 64'd0);
    end
    do_xfer(32'h0002_0020, 1'b0, 16'h0, 20);
    expect_hit("rst_after", 2, 32'h0000_0020, exp_mem[2]);

    for (int i = 0; i < 40; i++) begin
      a = (32'($urandom_range(0, 16)) << 16) | 32'($urandom_range(0, 65535));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      w = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      k = exp_slave(a);
      do_xfer(a, w, d, 20);
      if (k >= 0) begin
        if (w) exp_mem[k] = d;
        expect_hit("rnd", k, a - (32'(k) << 16), exp_mem[k]);
        check("rnd_we", 64'(sn_we), 64'(w));
      end else begin
        check("rnd_miss_stb", 64'(sn_stb), 64'd0);
        check("rnd_miss", {62'd0, r_ack, r_err}, 64'b01);
        check("rnd_miss_lat", 64'(r_n), 64'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
